legv8_sequencer: RTL and testbench

Multi-cycle control sequencer for the LEGv8 datapath. It fetches the 32-bit instruction presented by the instruction ROM, decodes a fixed instruction subset, and steps through FETCH/EXEC/LOAD2 states. In each state it drives the 94-bit ControlWord into DatapathLEGv8, and it samples the datapath status for conditional branches. It replaces the ad-hoc control unit and halts on any unsupported encoding.

---
 rtl/legv8_pkg.sv | 81 ++++++++
 rtl/legv8_decode.sv | 31 +++
 rtl/legv8_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_legv8_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: states, opcodes,
// function/PC-select codes and ControlWord field offsets.
package legv8_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_LOAD2 = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_ADD     = 4'd1,
    CLS_SUB     = 4'd2,
    CLS_AND     = 4'd3,
    CLS_ORR     = 4'd4,
    CLS_ADDI    = 4'd5,
    CLS_SUBI    = 4'd6,
    CLS_LDUR    = 4'd7,
    CLS_STUR    = 4'd8,
    CLS_CBZ     = 4'd9,
    CLS_B       = 4'd10
  } iclass_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [1:0] PS_HOLD  = 2'b00;
  localparam logic [1:0] PS_INC   = 2'b01;
  localparam logic [1:0] PS_BR    = 2'b10;
  localparam logic [1:0] PS_LDCON = 2'b11;

  localparam int CW_DA     = 0;
  localparam int CW_SA     = 5;
  localparam int CW_SB     = 10;
  localparam int CW_FS     = 15;
  localparam int CW_PS     = 20;
  localparam int CW_WR     = 22;
  localparam int CW_WM     = 23;
  localparam int CW_SL     = 24;
  localparam int CW_BSEL   = 25;
  localparam int CW_PCSEL  = 26;
  localparam int CW_EN_ALU = 27;
  localparam int CW_EN_MEM = 28;
  localparam int CW_EN_PC  = 29;
  localparam int CW_CONST  = 30;
  localparam int CW_W      = 94;

  // Opcode fields have different widths, so match each at its own width.
  function automatic iclass_t classify(input logic [31:0] ir);
    iclass_t c;
    c = CLS_ILLEGAL;
    if (ir[31:21] == OP_ADD)       c = CLS_ADD;
    else if (ir[31:21] == OP_SUB)  c = CLS_SUB;
    else if (ir[31:21] == OP_AND)  c = CLS_AND;
    else if (ir[31:21] == OP_ORR)  c = CLS_ORR;
    else if (ir[31:22] == OP_ADDI) c = CLS_ADDI;
    else if (ir[31:22] == OP_SUBI) c = CLS_SUBI;
    else if (ir[31:21] == OP_LDUR) c = CLS_LDUR;
    else if (ir[31:21] == OP_STUR) c = CLS_STUR;
    else if (ir[31:24] == OP_CBZ)  c = CLS_CBZ;
    else if (ir[31:26] == OP_B)    c = CLS_B;
    else                           c = CLS_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/legv8_decode.sv
// Combinational instruction decoder: class, illegal flag, register fields
// and the four immediate forms, all extended to 64 bits.
module legv8_decode
  import legv8_pkg::*;
(
  input  logic [31:0] i_ir,
  output iclass_t     o_iclass,
  output logic        o_illegal,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rn,
  output logic [4:0]  o_rm,
  output logic [63:0] o_imm12,
  output logic [63:0] o_imm_dt,
  output logic [63:0] o_imm_cb,
  output logic [63:0] o_imm_b
);

  assign o_iclass  = classify(i_ir);
  assign o_illegal = (classify(i_ir) == CLS_ILLEGAL);

  assign o_rd = i_ir[4:0];
  assign o_rn = i_ir[9:5];
  assign o_rm = i_ir[20:16];

  // Branch offsets are word counts, hence the trailing two zero bits.
  assign o_imm12  = {52'd0, i_ir[21:10]};
  assign o_imm_dt = {{55{i_ir[20]}}, i_ir[20:12]};
  assign o_imm_cb = {{43{i_ir[23]}}, i_ir[23:5], 2'b00};
  assign o_imm_b  = {{36{i_ir[25]}}, i_ir[25:0], 2'b00};

endmodule

// File: rtl/legv8_sequencer.sv
// Multi-cycle LEGv8 control sequencer: FETCH/EXEC/LOAD2/HALT FSM, instruction
// register, retired counter and ControlWord assembly for DatapathLEGv8.
module legv8_sequencer
  import legv8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic [4:0]       status,
  input  logic             enable,
  output logic [93:0]      ControlWord,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_ir;
  logic [31:0]      w_ir_nxt;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  iclass_t     w_cls;
  logic        w_ir_illegal;
  logic [4:0]  w_rd;
  logic [4:0]  w_rn;
  logic [4:0]  w_rm;
  logic [63:0] w_imm12;
  logic [63:0] w_imm_dt;
  logic [63:0] w_imm_cb;
  logic [63:0] w_imm_b;

  logic [63:0] w_const;
  logic        w_en_pc;
  logic        w_en_mem;
  logic        w_en_alu;
  logic        w_pcsel;
  logic        w_bsel;
  logic        w_sl;
  logic        w_wm;
  logic        w_wr;
  logic [1:0]  w_ps;
  logic [4:0]  w_fs;
  logic [4:0]  w_sb;
  logic [4:0]  w_sa;
  logic [4:0]  w_da;

  logic w_unused_ok;

  legv8_decode u_decode (
    .i_ir      (r_ir),
    .o_iclass  (w_cls),
    .o_illegal (w_ir_illegal),
    .o_rd      (w_rd),
    .o_rn      (w_rn),
    .o_rm      (w_rm),
    .o_imm12   (w_imm12),
    .o_imm_dt  (w_imm_dt),
    .o_imm_cb  (w_imm_cb),
    .o_imm_b   (w_imm_b)
  );

  // An illegal IR can never reach EXEC, so the decoder's flag is informational here.
  assign w_unused_ok = &{1'b0, status[4:1], w_ir_illegal};

  always_comb begin
    w_state_nxt = r_state;
    w_ir_nxt    = r_ir;
    w_retire    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (enable) begin
          w_ir_nxt    = instruction;
          w_state_nxt = (classify(instruction) == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (w_cls == CLS_LDUR) begin
          w_state_nxt = ST_LOAD2;
        end else begin
          w_state_nxt = ST_FETCH;
          w_retire    = 1'b1;
        end
      end
      ST_LOAD2: begin
        w_state_nxt = ST_FETCH;
        w_retire    = 1'b1;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_FETCH;
      r_ir      <= 32'd0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ir    <= w_ir_nxt;
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  always_comb begin
    w_const  = 64'd0;
    w_en_pc  = 1'b0;
    w_en_mem = 1'b0;
    w_en_alu = 1'b0;
    w_pcsel  = 1'b0;
    w_bsel   = 1'b0;
    w_sl     = 1'b0;
    w_wm     = 1'b0;
    w_wr     = 1'b0;
    w_ps     = PS_HOLD;
    w_fs     = 5'd0;
    w_sb     = 5'd0;
    w_sa     = 5'd0;
    w_da     = 5'd0;
    case (r_state)
      ST_EXEC: begin
        case (w_cls)
          CLS_ADD, CLS_SUB, CLS_AND, CLS_ORR: begin
            w_da     = w_rd;
            w_sa     = w_rn;
            w_sb     = w_rm;
            w_wr     = 1'b1;
            w_en_alu = 1'b1;
            w_ps     = PS_INC;
            case (w_cls)
              CLS_SUB: w_fs = FS_SUB;
              CLS_AND: w_fs = FS_AND;
              CLS_ORR: w_fs = FS_ORR;
              default: w_fs = FS_ADD;
            endcase
          end
          CLS_ADDI, CLS_SUBI: begin
            w_da     = w_rd;
            w_sa     = w_rn;
            w_bsel   = 1'b1;
            w_const  = w_imm12;
            w_fs     = (w_cls == CLS_SUBI) ? FS_SUB : FS_ADD;
            w_wr     = 1'b1;
            w_en_alu = 1'b1;
            w_ps     = PS_INC;
          end
          // First LDUR cycle only forms the address; the PC holds until LOAD2.
          CLS_LDUR: begin
            w_sa    = w_rn;
            w_bsel  = 1'b1;
            w_const = w_imm_dt;
            w_fs    = FS_ADD;
          end
          CLS_STUR: begin
            w_sa    = w_rn;
            w_sb    = w_rd;
            w_bsel  = 1'b1;
            w_const = w_imm_dt;
            w_fs    = FS_ADD;
            w_wm    = 1'b1;
            w_ps    = PS_INC;
          end
          CLS_CBZ: begin
            w_sa    = 5'd31;
            w_sb    = w_rd;
            w_fs    = FS_ADD;
            w_const = w_imm_cb;
            w_ps    = status[0] ? PS_BR : PS_INC;
          end
          CLS_B: begin
            w_const = w_imm_b;
            w_ps    = PS_BR;
          end
          default: w_ps = PS_HOLD;
        endcase
      end
      ST_LOAD2: begin
        w_sa     = w_rn;
        w_bsel   = 1'b1;
        w_const  = w_imm_dt;
        w_fs     = FS_ADD;
        w_da     = w_rd;
        w_en_mem = 1'b1;
        w_wr     = 1'b1;
        w_ps     = PS_INC;
      end
      default: w_ps = PS_HOLD;
    endcase
  end

  assign ControlWord = {w_const, w_en_pc, w_en_mem, w_en_alu, w_pcsel, w_bsel, w_sl,
                        w_wm, w_wr, w_ps, w_fs, w_sb, w_sa, w_da};
  assign state       = r_state;
  assign halted      = (r_state == ST_HALT);
  assign retired     = r_retired;

endmodule

// File: tb/tb_legv8_sequencer.sv
// Randomized self-checking bench for legv8_sequencer against a per-instruction
// behavioural model of the expected ControlWord sequence.
module tb_legv8_sequencer;

  localparam int CNT = 4;
  localparam int RMOD = 16;

  localparam int K_ILL = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_ORR = 4, K_ADDI = 5;
  localparam int K_SUBI = 6, K_LDUR = 7, K_STUR = 8, K_CBZ = 9, K_B = 10;

  logic           clock = 1'b0;
  logic           reset;
  logic [31:0]    instruction;
  logic [4:0]     status;
  logic           enable;
  logic [93:0]    ControlWord;
  logic [1:0]     state;
  logic           halted;
  logic [CNT-1:0] retired;

  int n_checks = 0;
  int n_pass   = 0;
  int m_retired = 0;
  bit m_halted = 1'b0;

  always #5 clock = ~clock;

  legv8_sequencer #(.CNT_W(CNT)) dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .status      (status),
    .enable      (enable),
    .ControlWord (ControlWord),
    .state       (state),
    .halted      (halted),
    .retired     (retired)
  );

  task automatic check_val(input string tag, input logic [93:0] got, input logic [93:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int kind_of(input logic [31:0] w);
    if (w[31:21] == 11'b10001011000) return K_ADD;
    if (w[31:21] == 11'b11001011000) return K_SUB;
    if (w[31:21] == 11'b10001010000) return K_AND;
    if (w[31:21] == 11'b10101010000) return K_ORR;
    if (w[31:22] == 10'b1001000100)  return K_ADDI;
    if (w[31:22] == 10'b1101000100)  return K_SUBI;
    if (w[31:21] == 11'b11111000010) return K_LDUR;
    if (w[31:21] == 11'b11111000000) return K_STUR;
    if (w[31:24] == 8'b10110100)     return K_CBZ;
    if (w[31:26] == 6'b000101)       return K_B;
    return K_ILL;
  endfunction

  // Expected ControlWord for instruction w in phase 1 (EXEC) or 2 (LOAD2).
  function automatic logic [93:0] exp_cw(input logic [31:0] w, input int phase, input logic z);
    int k;
    longint c;
    bit en_mem, en_alu, bsel, wm, wr;
    bit [1:0] ps;
    bit [4:0] fs, sa, sb, da;
    k = kind_of(w);
    c = 0; en_mem = 0; en_alu = 0; bsel = 0; wm = 0; wr = 0;
    ps = 2'd0; fs = 5'd0; sa = 5'd0; sb = 5'd0; da = 5'd0;
    if (k >= K_ADD && k <= K_ORR) begin
      da = w[4:0]; sa = w[9:5]; sb = w[20:16]; wr = 1; en_alu = 1; ps = 2'd1;
      fs = (k == K_ADD) ? 5'b01000 : (k == K_SUB) ? 5'b01001 : (k == K_AND) ? 5'b00000 : 5'b00100;
    end else if (k == K_ADDI || k == K_SUBI) begin
      da = w[4:0]; sa = w[9:5]; bsel = 1; c = longint'(w[21:10]);
      fs = (k == K_ADDI) ? 5'b01000 : 5'b01001; wr = 1; en_alu = 1; ps = 2'd1;
    end else if (k == K_LDUR) begin
      sa = w[9:5]; bsel = 1; c = longint'($signed(w[20:12])); fs = 5'b01000;
      if (phase == 2) begin
        da = w[4:0]; en_mem = 1; wr = 1; ps = 2'd1;
      end
    end else if (k == K_STUR) begin
      sa = w[9:5]; sb = w[4:0]; bsel = 1; c = longint'($signed(w[20:12]));
      fs = 5'b01000; wm = 1; ps = 2'd1;
    end else if (k == K_CBZ) begin
      sa = 5'd31; sb = w[4:0]; fs = 5'b01000;
      c = longint'($signed(w[23:5])) * 4; ps = z ? 2'd2 : 2'd1;
    end else if (k == K_B) begin
      c = longint'($signed(w[25:0])) * 4; ps = 2'd2;
    end
    return {c, 1'b0, en_mem, en_alu, 1'b0, bsel, 1'b0, wm, wr, ps, fs, sb, sa, da};
  endfunction

  function automatic logic [31:0] gen(input int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_ADD:  return {11'b10001011000, r[20:0]};
      K_SUB:  return {11'b11001011000, r[20:0]};
      K_AND:  return {11'b10001010000, r[20:0]};
      K_ORR:  return {11'b10101010000, r[20:0]};
      K_ADDI: return {10'b1001000100, r[21:0]};
      K_SUBI: return {10'b1101000100, r[21:0]};
      K_LDUR: return {11'b11111000010, r[20:12], 2'b00, r[9:0]};
      K_STUR: return {11'b11111000000, r[20:12], 2'b00, r[9:0]};
      K_CBZ:  return {8'b10110100, r[23:0]};
      K_B:    return {6'b000101, r[25:0]};
      default: return r;
    endcase
  endfunction

  // zsel: 0/1 force status[0], 2 = random.
  task automatic run_instr(input logic [31:0] w, input int stalls, input int zsel);
    logic z;
    int k;
    k = kind_of(w);
    for (int i = 0; i < stalls; i++) begin
      enable = 1'b0; instruction = $urandom; status = 5'($urandom);
      #1;
      check_val("stall_state", state, 0);
      check_val("stall_cw", ControlWord, 0);
      step();
    end
    enable = 1'b1; instruction = w; status = 5'($urandom);
    #1;
    check_val("fetch_state", state, 0);
    check_val("fetch_cw", ControlWord, 0);
    step();
    enable = 1'($urandom); instruction = $urandom;
    if (k == K_ILL) begin
      check_val("halt_state", state, 3);
      check_val("halt_flag", halted, 1);
      check_val("halt_cw", ControlWord, 0);
      m_halted = 1'b1;
      return;
    end
    z = (zsel == 2) ? 1'($urandom) : zsel[0];
    status = {4'($urandom), z};
    #1;
    check_val("exec_state", state, 1);
    check_val("exec_cw", ControlWord, exp_cw(w, 1, z));
    check_val("exec_retired", retired, m_retired);
    check_val("exec_halted", halted, 0);
    step();
    if (k == K_LDUR) begin
      status = 5'($urandom);
      #1;
      check_val("load2_state", state, 2);
      check_val("load2_cw", ControlWord, exp_cw(w, 2, status[0]));
      step();
    end
    m_retired = (m_retired + 1) % RMOD;
    check_val("done_state", state, 0);
    check_val("done_retired", retired, m_retired);
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'($urandom); instruction = $urandom;
    step();
    m_retired = 0; m_halted = 1'b0;
    check_val("rst_state", state, 0);
    check_val("rst_cw", ControlWord, 0);
    check_val("rst_retired", retired, 0);
    check_val("rst_halted", halted, 0);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] ldur_w;
    logic [31:0] w;
    int k;
    reset = 1'b0; enable = 1'b0; instruction = 32'd0; status = 5'd0;
    step();
    do_reset();

    run_instr(32'h910017E1, 0, 2);
    ldur_w = {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd2};
    run_instr(ldur_w, 1, 2);
    run_instr({8'b10110100, 19'd4, 5'd3}, 0, 1);
    run_instr({8'b10110100, 19'd4, 5'd3}, 0, 0);

    run_instr(32'd0, 0, 2);
    for (int i = 0; i < 10; i++) begin
      enable = 1'($urandom); instruction = $urandom; status = 5'($urandom);
      step();
      check_val("halt_hold_state", state, 3);
      check_val("halt_hold_cw", ControlWord, 0);
      check_val("halt_hold_flag", halted, 1);
    end
    do_reset();

    run_instr(gen(K_ADD), 0, 2);
    enable = 1'b1; instruction = ldur_w;
    step();
    enable = 1'b0;
    step();
    check_val("mid_load2_state", state, 2);
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instruction = $urandom;
      step();
      check_val("post_rst_state", state, 0);
      check_val("post_rst_cw", ControlWord, 0);
      check_val("post_rst_retired", retired, 0);
    end

    for (int i = 0; i < 16; i++) run_instr(gen(K_ADD), 0, 2);
    check_val("wrap_retired", retired, 0);

    for (int n = 0; n < 300; n++) begin
      k = ($urandom_range(0, 20) == 0) ? K_ILL : int'($urandom_range(1, 10));
      w = gen(k);
      run_instr(w, int'($urandom_range(0, 2)), 2);
      if (m_halted) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
